// File: rtl/s2p_stream.sv
// Multi-lane serial-to-parallel spike deserializer with output FIFO and valid/ready handshake.
// Groups carry a per-lane activity mask and a wrapping group index.
module s2p_stream #(
  parameter int unsigned P          = 8,
  parameter int unsigned C          = 1,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned IDXW       = 8,
  parameter int unsigned SKIP_EMPTY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [C-1:0]      spike_s,
  input  logic              flush,
  output logic              in_ready,
  output logic [C*P-1:0]    spike_p,
  output logic [C-1:0]      active_group,
  output logic [IDXW-1:0]   group_idx,
  output logic              valid,
  input  logic              ready,
  output logic              dropped
);

  localparam int unsigned CNTW = $clog2(P);
  localparam int unsigned EW   = $clog2(P + 1);
  localparam int unsigned AW   = $clog2(DEPTH);

  logic [C-1:0][P-1:0] sr_q;
  logic [C-1:0][P-1:0] cur;
  logic [CNTW-1:0]     cnt_q;
  logic [IDXW-1:0]     gcnt_q;
  logic [EW-1:0]       eff;
  logic [EW-1:0]       pad;
  logic [C*P-1:0]      word;
  logic [C-1:0]        mask;
  logic                accept;
  logic                flush_ok;
  logic                complete;
  logic                word_zero;
  logic                push;
  logic                pop;
  logic                drop;

  logic [C*P-1:0]      mem_data [DEPTH];
  logic [C-1:0]        mem_mask [DEPTH];
  logic [IDXW-1:0]     mem_idx  [DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [AW:0]         count_q;
  logic                full;

  assign full     = (count_q == (AW + 1)'(DEPTH));
  assign in_ready = !full;
  assign valid    = (count_q != '0);
  assign pop      = valid && ready;

  always_comb begin
    accept    = en && in_ready;
    flush_ok  = flush && in_ready;
    eff       = EW'(cnt_q) + EW'(accept);
    complete  = (accept && (cnt_q == CNTW'(P - 1))) || (flush_ok && (eff != '0));
    // Left-align the held bits so the first-received bit lands at P-1; low bits are zero padding.
    pad       = EW'(P) - eff;
    cur       = '0;
    word      = '0;
    mask      = '0;
    for (int c = 0; c < C; c++) begin
      cur[c]            = accept ? {sr_q[c][P-2:0], spike_s[c]} : sr_q[c];
      word[c*P +: P]    = cur[c] << pad;
      mask[c]           = |word[c*P +: P];
    end
    word_zero = ~|word;
    drop      = complete && (SKIP_EMPTY != 0) && word_zero;
    push      = complete && !drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      dropped <= 1'b0;
    end else begin
      dropped <= drop;
      if (complete) begin
        sr_q   <= '0;
        cnt_q  <= '0;
        gcnt_q <= gcnt_q + 1'b1;
      end else if (accept) begin
        sr_q  <= cur;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= word;
      mem_mask[wr_ptr_q] <= mask;
      mem_idx[wr_ptr_q]  <= gcnt_q;
    end
  end

  assign spike_p      = valid ? mem_data[rd_ptr_q] : '0;
  assign active_group = valid ? mem_mask[rd_ptr_q] : '0;
  assign group_idx    = valid ? mem_idx[rd_ptr_q]  : '0;

endmodule

// File: doc/s2p_stream.md
# s2p_stream

Multi-lane serial-to-parallel spike deserializer with an output FIFO and valid/ready handshake. It packs C serial spike lanes in lockstep into P-bit groups and tags each group with a per-lane activity mask and a wrapping group index. It can close a partial group early (flush) and can drop all-zero groups. It sits between the serial spike source and the group-parallel neuron/synapse datapath, absorbs consumer back-pressure, and throttles the source through `in_ready`.

## Interface
- `P`, 8: bits per group, ≥2.
- `C`, 1: number of serial lanes, ≥1.
- `DEPTH`, 2: output FIFO entries, power of 2, ≥2.
- `IDXW`, 8: group index width.
- `SKIP_EMPTY`, 0: 1 = groups with no set bit on any lane are discarded, not enqueued.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  input strobe; one bit per lane is accepted when `en && in_ready`.
- `spike_s`  in  C  serial spike bit, one per lane.
- `flush`  in  1  close the current partial group, zero-padded.
- `in_ready`  out  1  input may be accepted (FIFO not full).
- `spike_p`  out  C*P  head group; lane c occupies [c*P +: P].
- `active_group`  out  C  head group per-lane OR of its P bits.
- `group_idx`  out  IDXW  head group index.
- `valid`  out  1  FIFO head valid.
- `ready`  in  1  consumer accepts head.
- `dropped`  out  1  one-cycle pulse: an all-zero group was discarded (SKIP_EMPTY=1 only).

## Operation
- Per lane: P-bit shift register. On accept, new bit enters bit 0 and existing bits shift up. After P accepts, the first-received bit sits at bit P-1.
- Bit counter `cnt` runs 0..P-1. It increments on accept and returns to 0 on group completion.
- Group completion: an accept with `cnt==P-1`, or `flush` with a nonzero effective count.
  - Effective count = `cnt`, plus 1 if a bit is accepted in the same cycle.
  - `flush` with effective count 0 is a no-op.
  - `flush` with `in_ready` low is ignored, and any `en` in that cycle is also not accepted.
- Flush padding: the word is formed as if zeros were shifted in until P bits were held. The first-received bit is therefore still at P-1 and the unfilled low bits are 0.
- On completion:
  - Form the word, including a same-cycle accepted bit.
  - Compute the per-lane OR mask.
  - Assign index `gcnt`, then increment `gcnt` mod 2^IDXW.
  - Clear the shift registers and `cnt`.
  - Enqueue the word, unless SKIP_EMPTY=1 and the word is all zero. In that case pulse `dropped`; the index is still consumed.
- `in_ready` = !FIFO full, combinational from the FIFO count only. It is deasserted whenever the FIFO is full, even mid-group.
- FIFO entry = {data, mask, idx}.
  - `valid` = !empty.
  - Pop on `valid && ready`.
  - Push and pop in the same cycle are both performed and the count is unchanged. This is legal when empty (push only) and when not full.
  - Pointers wrap mod DEPTH.
- When the FIFO is empty, `spike_p`, `active_group` and `group_idx` drive 0. Head contents are stable while `valid && !ready`.

## Timing
- Reset (async assert, synchronous-safe deassert by the integrator):
  - FIFO empty; `valid`=0, `spike_p`=0, `active_group`=0, `group_idx`=0, `dropped`=0.
  - `in_ready`=1; `cnt`=0; shift registers 0; `gcnt`=0.
- Reset mid-group or with a non-empty FIFO discards everything. No partial group survives.
- Latency: a group completed at edge k is visible with `valid`=1 in the cycle after edge k (one cycle). `dropped` is asserted in that same cycle.
- Throughput: one bit per lane per cycle sustained when `ready` is held high. This includes back-to-back groups with no bubble.
- Full FIFO plus pop: `in_ready` stays low during that cycle and rises the cycle after the pop edge.
- `gcnt` wraps from 2^IDXW-1 to 0.

## Test plan
- Continuous traffic: P=8, C=2, `ready`=1, `en`=1 for 16 cycles. Lane0 = 1,0,0,0,0,0,0,1; lane1 = zeros -> first group `spike_p`[7:0]=0x81, [15:8]=0x00, `active_group`=2'b01, `group_idx`=0, `valid` one cycle after the 8th accept. Second group has idx 1, with no bubble.
- Flush: P=8, after 3 accepted bits 1,1,0, pulse `flush` -> `spike_p`=0xC0 (first-received bit at bit 7, low 5 bits zero padding), idx 0, `cnt` back to 0. A flush with `cnt`=0 produces nothing.
- Back-pressure: DEPTH=2, `ready`=0, stream 3 groups -> `in_ready` falls after the 2nd group is enqueued, the 3rd group's bits are stalled, and the head is held stable. Raise `ready` for 1 cycle -> `in_ready` rises the next cycle and the groups drain in idx order 0,1,2.
- SKIP_EMPTY=1: feed one all-zero group, then group 0x01 -> `dropped` pulses once, no `valid` for the zero group, and the next group appears with `group_idx`=1.
- Index wrap: IDXW=2, 5 groups -> indices 0,1,2,3,0.
- Reset mid-operation: assert `rst` asynchronously after 4 bits with 1 FIFO entry held -> all outputs 0 immediately and `in_ready`=1. The next full group gets idx 0 and contains none of the pre-reset bits.
